// File: rtl/cpu_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_uart_mmio
//  Description : Memory-mapped 8N1 UART on the CPU data port, with a TX FIFO
//                and an optional receiver (enabled by defining UART_RX_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_uart_mmio #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [3:0]  data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wenable,
    output logic [31:0] data_rdata,
    output logic        tx,
    input  logic        rx
);

    localparam int c_aw = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic [1:0]   w_word;
    logic         w_txdata_wr;
    logic         w_status_wr;
    logic         w_div_lo_wr;
    logic         w_div_hi_wr;
    logic         w_rxack_wr;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         w_tx_busy;
    logic [15:0]  w_div_eff;
    logic [7:0]   w_head;

    logic [7:0]   r_mem [FIFO_DEPTH];
    logic [c_aw:0] r_wptr;
    logic [c_aw:0] r_rptr;
    logic         r_ovf;
    logic [15:0]  r_div;

    tx_state_t    r_tx_state;
    logic [15:0]  r_baud;
    logic [7:0]   r_tx_shift;
    logic [2:0]   r_tx_bit;
    logic         r_tx;

    logic [7:0]   w_rx_byte;
    logic         w_rx_valid;
    logic         w_rx_overrun;
    logic         w_rx_ferr;

    assign w_word      = data_addr[3:2];
    assign w_txdata_wr = sel && (w_word == 2'd0) && data_wenable[0];
    assign w_status_wr = sel && (w_word == 2'd1) && data_wenable[0];
    assign w_div_lo_wr = sel && (w_word == 2'd2) && data_wenable[0];
    assign w_div_hi_wr = sel && (w_word == 2'd2) && data_wenable[1];
    assign w_rxack_wr  = sel && (w_word == 2'd3) && data_wenable[0];

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_head    = r_mem[r_rptr[c_aw-1:0]];
    assign w_push    = w_txdata_wr && !w_full;
    assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_tx_busy = (r_tx_state != TX_IDLE);

    // The shifter takes a byte when idle, or at the last stop-bit cycle for gapless frames
    assign w_pop = !w_empty &&
                   ((r_tx_state == TX_IDLE) ||
                    ((r_tx_state == TX_STOP) && (r_baud == 16'd1)));

    assign tx = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_aw-1:0]] <= data_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_div  <= 16'(CLK_DIV);
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_status_wr && data_wdata[3]) r_ovf <= 1'b0;
            if (w_txdata_wr && w_full)        r_ovf <= 1'b1;
            if (w_div_lo_wr) r_div[7:0]  <= data_wdata[7:0];
            if (w_div_hi_wr) r_div[15:8] <= data_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx       <= 1'b1;
            r_baud     <= 16'd0;
            r_tx_shift <= 8'd0;
            r_tx_bit   <= 3'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_tx_shift <= w_head;
                        r_tx       <= 1'b0;
                        r_baud     <= w_div_eff;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_baud == 16'd1) begin
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= 3'd0;
                        r_baud     <= w_div_eff;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (r_baud == 16'd1) begin
                        r_baud <= w_div_eff;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (r_baud == 16'd1) begin
                        if (w_pop) begin
                            r_tx_shift <= w_head;
                            r_tx       <= 1'b0;
                            r_baud     <= w_div_eff;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_EN
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t    r_rx_state;
    logic         r_rx_s1;
    logic         r_rx_s2;
    logic         r_rx_d;
    logic [15:0]  r_rx_cnt;
    logic [2:0]   r_rx_bit;
    logic [7:0]   r_rx_shift;
    logic [7:0]   r_rx_byte;
    logic         r_rx_valid;
    logic         r_rx_overrun;
    logic         r_rx_ferr;
    logic [15:0]  w_half;
    logic         w_unused;

    assign w_half = (w_div_eff[15:1] == 15'd0) ? 16'd1 : {1'b0, w_div_eff[15:1]};

    // Event flags are written after the software clears so a same-cycle event wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= RX_IDLE;
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_d       <= 1'b1;
            r_rx_cnt     <= 16'd0;
            r_rx_bit     <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_rx_byte    <= 8'd0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            if (w_rxack_wr) r_rx_valid <= 1'b0;
            if (w_status_wr && data_wdata[5]) r_rx_overrun <= 1'b0;
            if (w_status_wr && data_wdata[6]) r_rx_ferr    <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_d && !r_rx_s2) begin
                        r_rx_cnt   <= w_half;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == 16'd1) begin
                        if (r_rx_s2) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_cnt   <= w_div_eff;
                            r_rx_bit   <= 3'd0;
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == 16'd1) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_cnt   <= w_div_eff;
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == 16'd1) begin
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s2) begin
                            r_rx_byte  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            if (r_rx_valid) r_rx_overrun <= 1'b1;
                        end else begin
                            r_rx_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_rx_byte    = r_rx_byte;
    assign w_rx_valid   = r_rx_valid;
    assign w_rx_overrun = r_rx_overrun;
    assign w_rx_ferr    = r_rx_ferr;
    assign w_unused     = &{1'b0, data_addr[1:0], data_wdata[31:16], data_wenable[3:2]};
`else
    logic w_unused;

    assign w_rx_byte    = 8'd0;
    assign w_rx_valid   = 1'b0;
    assign w_rx_overrun = 1'b0;
    assign w_rx_ferr    = 1'b0;
    assign w_unused     = &{1'b0, rx, w_rxack_wr, data_addr[1:0],
                            data_wdata[31:16], data_wenable[3:2]};
`endif

    always_comb begin
        data_rdata = 32'd0;
        if (sel) begin
            case (w_word)
                2'd0:    data_rdata = {24'd0, w_rx_byte};
                2'd1:    data_rdata = {25'd0, w_rx_ferr, w_rx_overrun, w_rx_valid,
                                       r_ovf, w_tx_busy, w_empty, w_full};
                2'd2:    data_rdata = {16'd0, r_div};
                default: data_rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_uart_mmio
//  Description : Directed bench for cpu_uart_mmio with a TX frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_uart_mmio;

    localparam int C_CLK_DIV = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [3:0]  data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wenable;
    logic [31:0] data_rdata;
    logic        tx;
    logic        rx;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en  = 1'b0;
    int          mon_div = 4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_uart_mmio #(.CLK_DIV(C_CLK_DIV), .FIFO_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wenable (data_wenable),
        .data_rdata   (data_rdata),
        .tx           (tx),
        .rx           (rx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
        sel = 1'b1; data_addr = a; data_wdata = d; data_wenable = we;
        @(negedge clk);
        sel = 1'b0; data_wenable = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; data_addr = a; data_wenable = 4'h0;
        #1;
        d = data_rdata;
        sel = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b);
        exp_q.push_back(b);
        wr(4'h0, {24'd0, b}, 4'h1);
    endtask

    // Counts negedges until tx_busy drops; a run-away returns the limit
    task automatic wait_busy_low(input int limit, output int n);
        logic [31:0] s;
        n = 0;
        rd(4'h4, s);
        while (s[2] && n < limit) begin
            @(negedge clk);
            n++;
            rd(4'h4, s);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        rx = 1'b0;
        repeat (d) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (d) @(negedge clk);
        end
        rx = stop;
        repeat (d) @(negedge clk);
        rx = 1'b1;
        repeat (2 * d) @(negedge clk);
    endtask

    // Decodes every frame on tx, cycle by cycle, against the expected-byte queue
    initial begin : tx_monitor
        logic [9:0] obs;
        logic       glitch, aborted, first;
        logic [7:0] e;
        int         d;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                d = mon_div; obs = '0; glitch = 1'b0; aborted = 1'b0; first = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < d; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!mon_en) aborted = 1'b1;
                        if (c == 0) begin
                            first  = tx;
                            obs[b] = tx;
                        end else if (tx !== first) begin
                            glitch = 1'b1;
                        end
                    end
                end
                if (!aborted) begin
                    total++;
                    assert (exp_q.size() > 0) else begin
                        bad++;
                        $error("FAIL sb_unexpected_frame: observed=%h expected=none", obs[8:1]);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        total++;
                        assert ({glitch, obs} === {1'b0, 1'b1, e, 1'b0}) else begin
                            bad++;
                            $error("FAIL sb_frame: observed=%h glitch=%0b expected=%h",
                                   obs, glitch, {1'b1, e, 1'b0});
                        end
                    end
                end
            end
        end
    end

    initial begin : timeout
        #300000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] r;
        int          n;
        int          c0;

        rst = 1'b1; sel = 1'b0; data_addr = 4'h0; data_wdata = 32'd0;
        data_wenable = 4'h0; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_tx", {31'd0, tx}, 32'd1);
        rd(4'h4, r); chk("rst_status", r, 32'h2);
        rd(4'h8, r); chk("rst_div", r, C_CLK_DIV);
        rd(4'h0, r); chk("rst_rxdata", r, 32'd0);
        mon_en = 1'b1;

        // Deselected access: no read data, no state change
        sel = 1'b0; data_addr = 4'h8; data_wdata = 32'hFFFF_FFFF; data_wenable = 4'hF;
        #1 chk("nosel_rdata", data_rdata, 32'd0);
        @(negedge clk);
        data_addr = 4'h0;
        @(negedge clk);
        data_addr = 4'h4;
        @(negedge clk);
        data_wenable = 4'h0;
        rd(4'h8, r); chk("nosel_div", r, C_CLK_DIV);
        rd(4'h4, r); chk("nosel_status", r, 32'h2);
        chk("nosel_tx", {31'd0, tx}, 32'd1);

        // Single frame, div=4: exact start latency and 10*div frame length
        @(negedge clk);
        wr(4'h8, 32'd4, 4'h3);
        rd(4'h8, r); chk("div4_read", r, 32'd4);
        mon_div = 4;
        @(negedge clk);
        push_tx(8'h55);
        chk("f55_tx_before_pop", {31'd0, tx}, 32'd1);
        rd(4'h4, r); chk("f55_status_queued", r, 32'h0);
        @(negedge clk);
        chk("f55_tx_start", {31'd0, tx}, 32'd0);
        rd(4'h4, r); chk("f55_status_busy", r, 32'h6);
        wait_busy_low(200, n);
        chk("f55_busy_cycles", n, 32'd40);

        // FIFO fill, overflow drop, W1C of ovf, contiguous frames, div=2
        @(negedge clk);
        wr(4'h8, 32'd2, 4'h3);
        mon_div = 2;
        push_tx(8'h10);
        c0 = cyc;
        for (int i = 1; i < 17; i++) push_tx(8'h10 + 8'(i));
        wr(4'h0, 32'hEE, 4'h1);
        rd(4'h4, r); chk("ovf_status_set", r, 32'hD);
        @(negedge clk);
        wr(4'h4, 32'h8, 4'h1);
        rd(4'h4, r); chk("ovf_status_clr", r, 32'h5);
        wait_busy_low(1000, n);
        chk("burst_total_cycles", cyc - c0, 32'd341);
        chk("burst_sb_drained", exp_q.size(), 32'd0);

        // div=0 behaves as 1 cycle per bit
        @(negedge clk);
        wr(4'h8, 32'd0, 4'h3);
        rd(4'h8, r); chk("div0_read", r, 32'd0);
        mon_div = 1;
        @(negedge clk);
        push_tx(8'hA5);
        @(negedge clk);
        chk("div0_tx_start", {31'd0, tx}, 32'd0);
        wait_busy_low(100, n);
        chk("div0_busy_cycles", n, 32'd10);
        repeat (3) @(negedge clk);
        chk("div0_sb_drained", exp_q.size(), 32'd0);

        // Reset in the middle of a data bit, with a second byte still queued
        wr(4'h8, 32'd4, 4'h1);
        mon_en = 1'b0;
        wr(4'h0, 32'h3C, 4'h1);
        wr(4'h0, 32'h99, 4'h1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        rd(4'h4, r); chk("midrst_status", r, 32'h2);
        rd(4'h8, r); chk("midrst_div", r, C_CLK_DIV);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("postrst_tx", {31'd0, tx}, 32'd1);
        rd(4'h4, r); chk("postrst_status", r, 32'h2);
        mon_en = 1'b1;

        // Receive path
        @(negedge clk);
        wr(4'h8, 32'd8, 4'h3);
`ifdef UART_RX_EN
        send_rx(8'hA3, 1'b1, 8);
        rd(4'h4, r); chk("rx_valid_status", r, 32'h12);
        rd(4'h0, r); chk("rx_data_a3", r, 32'hA3);
        @(negedge clk);
        send_rx(8'h5A, 1'b1, 8);
        rd(4'h4, r); chk("rx_overrun_status", r, 32'h32);
        rd(4'h0, r); chk("rx_data_5a", r, 32'h5A);
        @(negedge clk);
        send_rx(8'h11, 1'b0, 8);
        rd(4'h4, r); chk("rx_ferr_status", r, 32'h72);
        rd(4'h0, r); chk("rx_data_kept", r, 32'h5A);
        @(negedge clk);
        wr(4'hC, 32'h1, 4'h1);
        wr(4'h4, 32'h60, 4'h1);
        rd(4'h4, r); chk("rx_cleared_status", r, 32'h2);
`else
        send_rx(8'hA3, 1'b1, 8);
        rd(4'h4, r); chk("norx_status", r, 32'h2);
        rd(4'h0, r); chk("norx_rxdata", r, 32'h0);
`endif
        chk("final_sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_uart_mmio.md
# cpu_uart_mmio

Memory-mapped UART that sits directly downstream of the single-cycle CPU data port. It consumes the CPU's address, write data and per-byte write enables, and returns read data combinationally in the same cycle. It serialises bytes through a TX FIFO onto an 8N1 line, and optionally receives bytes into a holding register. Address decode to `sel` happens in the top-level bus mux.

## Interface
Parameters:
- `CLK_DIV`, default 868: reset value of the divider register, in clock cycles per bit.
- `FIFO_DEPTH`, default 16: TX FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sel` input 1: CPU data access targets this block.
- `data_addr` input 4: byte offset within the block; bits [1:0] are ignored.
- `data_wdata` input 32: write data.
- `data_wenable` input 4: per-byte write enables.
- `data_rdata` output 32: combinational read data; 0 when `sel`=0.
- `tx` output 1: serial out; idle high.
- `rx` input 1: serial in; ignored unless RX is compiled in.

## Operation
- Register map (word offsets):
  - 0x0 TXDATA/RXDATA
  - 0x4 STATUS
  - 0x8 DIV
  - 0xC RXACK
- Writes take effect only when `sel`=1, at the clock edge.
- Reads have no side effects, because the CPU bus has no read strobe.
- TXDATA write with `data_wenable[0]`:
  - If the FIFO is not full, push `data_wdata[7:0]`.
  - If it is full, drop the byte and set sticky `ovf`.
  - Fullness is judged before the edge, so a push into a full FIFO is dropped even if a pop happens in the same cycle.
- Read 0x0 returns `{24'b0, rx_byte}`.
- STATUS read layout:
  - [0] `tx_full`
  - [1] `tx_empty`
  - [2] `tx_busy` (shifter not IDLE)
  - [3] `ovf`
  - [4] `rx_valid`
  - [5] `rx_overrun`
  - [6] `rx_ferr`
  - all other bits 0.
- STATUS write with `data_wenable[0]` clears each of bits 3, 5 and 6 whose `data_wdata` bit is 1 (write-1-to-clear).
- DIV register (16 bits):
  - `data_wenable[0]` writes the low byte; `data_wenable[1]` writes the high byte.
  - Read returns `{16'b0, div}`.
  - Effective divisor is `max(div, 1)`.
  - A new value takes effect at the next bit boundary.
- RXACK write with `data_wenable[0]` clears `rx_valid`.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2·FIFO_DEPTH.
  - Empty: pointers equal.
  - Full: pointers differ only in the MSB.
- TX state machine:
  - IDLE: if the FIFO is non-empty, pop the head into the shifter and go to START. Otherwise `tx`=1.
  - START: `tx`=0 for one bit time, then DATA.
  - DATA: 8 bits, LSB first, each held one bit time, then STOP.
  - STOP: `tx`=1 for one bit time. At the end of the bit time, if the FIFO is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- A bit time is a down-counter reloaded with the effective divisor.
- Reset values:
  - `tx`=1, state IDLE, FIFO empty.
  - `ovf`, `rx_valid`, `rx_overrun`, `rx_ferr` = 0; `rx_byte`=0.
  - `div`=CLK_DIV.
- Reset asserted mid-frame: `tx` is high from the next edge and queued bytes are discarded.

## Timing
- TXDATA write at edge N pushes the byte.
- At edge N+1 the byte is popped and `tx` falls, provided the shifter was IDLE.
- One frame is exactly 10·div cycles.
- Back-to-back frames are contiguous: the next start bit begins on the cycle after the last stop-bit cycle.
- STATUS reflects each edge's updates combinationally in the following cycle.
- `data_rdata` has zero latency.

## Configuration
- `UART_RX_EN` defined:
  - `rx` passes through a 2-flop synchroniser.
  - A falling edge arms the receiver; the start bit is re-checked at div/2 cycles.
  - If the line is high at that check, the receiver returns to idle.
  - Data bits are sampled every div cycles, LSB first, then the stop bit.
  - Stop bit = 1: store the byte and set `rx_valid`. If `rx_valid` was already set, overwrite the byte and set `rx_overrun`.
  - Stop bit = 0: discard the byte and set `rx_ferr`.
- `UART_RX_EN` undefined: no receiver logic; `rx` is unused; STATUS bits 4–6 and RXDATA read as 0.

## Test plan
- Reset, then write 0x55 to TXDATA with div=4: `tx` low for 4 cycles starting one edge after the write, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; `tx_busy` falls at the 41st cycle after the pop.
- Push 16 bytes with div=2 while the shifter is idle: the 17th push is accepted (one byte already popped). The next push sets `ovf` and is dropped. Writing 0x8 to STATUS clears `ovf`. Frames run contiguously with no idle cycles.
- Write div=0 (both lanes): bit time is 1 cycle and a frame is 10 cycles. Read 0x8 returns 0.
- Assert `rst` mid-DATA: `tx`=1, `tx_empty`=1 and div=CLK_DIV on the next cycle.
- With `UART_RX_EN`, div=8, drive 0xA3 on `rx`: `rx_valid`=1 and RXDATA=0xA3. Send a second frame without ack: `rx_overrun`=1. Send a frame with stop=0: `rx_ferr`=1 and the byte is unchanged.
- `sel`=0 with `data_wenable`=4'hF: no state change, `data_rdata`=0.
